// File: rtl/salaga_pkg.sv
// salaga_pkg: definitions shared by the data-memory responder slice.
//   state_t : responder FSM state encoding (IDLE, WAIT, RESP)
//   CNT_W   : width of the latency down-counter (holds values 0..15)
package salaga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-wide storage with per-byte write enables and a
// combinational read port. Contents are not reset.
// Ports:
//   clk     - write clock (rising edge)
//   i_we    - write enable for the addressed word
//   i_be    - byte-lane enables; bit b covers bits 8b+7:8b
//   i_addr  - word index (shared by read and write)
//   i_wdata - write data
//   o_rdata - current contents of the addressed word
module dmem_array #(
    parameter int WORDS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed,
// parameterised response latency.
// Ports:
//   clk               - clock, all state on the rising edge
//   reset             - asynchronous, active-low reset
//   ip_data_addr      - byte address of the request (bits 1:0 ignored)
//   ip_data_wr        - write request
//   ip_data_mask      - byte-lane enables for writes
//   ip_data_from_proc - write data
//   ip_data_rd        - read request
//   op_data_valid     - one-cycle response strobe
//   op_data_from_dmem - read data (stored word, also on write responses)
//   op_data_err       - out-of-range index or rd+wr both asserted
module dmem_responder
    import salaga_pkg::*;
#(
    parameter int SIZE_IN_BYTES = 64,
    parameter int LATENCY       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_from_dmem,
    output logic        op_data_err
);

    localparam int WORDS = SIZE_IN_BYTES / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    localparam logic [29:0]      WORDS_L  = 30'(WORDS);

    state_t          r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]   r_idx;
    logic [3:0]      r_mask;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_wr;
    logic            r_err;

    logic            w_accept;
    logic            w_req_err;
    logic            w_to_resp;
    logic            w_we;
    logic            w_sel_err;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_arr_rdata;
    logic            w_unused_addr_lo;

    assign w_unused_addr_lo = ^ip_data_addr[1:0];

    assign w_accept  = (r_state == IDLE) && (ip_data_rd || ip_data_wr);
    assign w_req_err = (ip_data_rd && ip_data_wr) || (ip_data_addr[31:2] >= WORDS_L);

    // With LATENCY=0 the read data is registered on the accepting edge,
    // so the array must be addressed straight from the request in IDLE.
    assign w_idx     = (r_state == IDLE) ? ip_data_addr[AW+1:2] : r_idx;
    assign w_sel_err = (r_state == IDLE) ? w_req_err : r_err;

    // Write lands on the edge that ends RESP; errored requests never write.
    assign w_we = (r_state == RESP) && r_wr && !r_err;

    always_comb begin
        w_next    = r_state;
        w_to_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_next    = RESP;
                        w_to_resp = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next    = RESP;
                    w_to_resp = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_idx   <= ip_data_addr[AW+1:2];
                r_mask  <= ip_data_mask;
                r_wdata <= ip_data_from_proc;
                r_wr    <= ip_data_wr;
                r_err   <= w_req_err;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_to_resp) begin
                r_rdata <= w_sel_err ? '0 : w_arr_rdata;
            end
        end
    end

    dmem_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (r_mask),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign op_data_valid     = (r_state == RESP);
    assign op_data_from_dmem = op_data_valid ? r_rdata : '0;
    assign op_data_err       = op_data_valid ? r_err : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. Two instances:
// u_l2 (LATENCY=2) and u_l0 (LATENCY=0), sharing clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] a2 = '0, d2 = '0, q2;
    logic [3:0]  m2 = '0;
    logic        rd2 = 1'b0, wr2 = 1'b0, v2, e2;

    logic [31:0] a0 = '0, d0 = '0, q0;
    logic [3:0]  m0 = '0;
    logic        rd0 = 1'b0, wr0 = 1'b0, v0, e0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t sq2[$];
    exp_t sq0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.SIZE_IN_BYTES(64), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .ip_data_addr(a2), .ip_data_wr(wr2), .ip_data_mask(m2),
        .ip_data_from_proc(d2), .ip_data_rd(rd2),
        .op_data_valid(v2), .op_data_from_dmem(q2), .op_data_err(e2)
    );

    dmem_responder #(.SIZE_IN_BYTES(64), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .ip_data_addr(a0), .ip_data_wr(wr0), .ip_data_mask(m0),
        .ip_data_from_proc(d0), .ip_data_rd(rd0),
        .op_data_valid(v0), .op_data_from_dmem(q0), .op_data_err(e0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int w, input logic v, input logic [31:0] d, input logic e);
        exp_t it;
        bit   have;
        have = (w == 0) ? (sq0.size() > 0) : (sq2.size() > 0);
        if (have) it = (w == 0) ? sq0[0] : sq2[0];
        if (have && it.cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL L%0d missed_response: no valid at cycle %0d (now %0d)", w, it.cyc, cyc);
            if (w == 0) void'(sq0.pop_front()); else void'(sq2.pop_front());
            have = (w == 0) ? (sq0.size() > 0) : (sq2.size() > 0);
            if (have) it = (w == 0) ? sq0[0] : sq2[0];
        end
        if (v) begin
            if (!have) begin
                n_chk++;
                n_fail++;
                $display("FAIL L%0d unexpected_valid: data %h err %b at cycle %0d", w, d, e, cyc);
            end else begin
                if (w == 0) void'(sq0.pop_front()); else void'(sq2.pop_front());
                chk($sformatf("L%0d resp_cycle", w), 32'(cyc), 32'(it.cyc));
                chk($sformatf("L%0d resp_err", w), {31'b0, e}, {31'b0, it.err});
                if (it.chk) chk($sformatf("L%0d resp_data", w), d, it.data);
            end
        end else begin
            chk($sformatf("L%0d idle_outputs", w), {e, d[30:0]} | {31'b0, d[31]}, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon(2, v2, q2, e2);
        mon(0, v0, q0, e0);
    end

    // Issue one request, push its expectation, and wait until it is retired.
    task automatic issue(input int w, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit exp_e, input bit chk_d);
        exp_t it;
        int   lat;
        lat = (w == 0) ? 0 : 2;
        @(negedge clk);
        if (w == 0) begin
            rd0 = rd; wr0 = wr; a0 = addr; m0 = mask; d0 = wd;
        end else begin
            rd2 = rd; wr2 = wr; a2 = addr; m2 = mask; d2 = wd;
        end
        it.data = exp_d; it.err = exp_e; it.chk = chk_d; it.cyc = cyc + 1 + lat;
        if (w == 0) sq0.push_back(it); else sq2.push_back(it);
        @(posedge clk);
        #1;
        if (w == 0) begin
            rd0 = 1'b0; wr0 = 1'b0; a0 = 32'hFFFF_FFF0; d0 = '1;
        end else begin
            rd2 = 1'b0; wr2 = 1'b0; a2 = 32'hFFFF_FFF0; d2 = '1;
        end
        repeat (lat + 2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t it;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, v2}, 32'h0);
        chk("reset_data", q2, 32'h0);
        chk("reset_err", {31'b0, e2}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Full write, readback, ignored addr[1:0], mask-0000 no-op write
        issue(2, 0, 1, 32'h4, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(2, 1, 0, 32'h4, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        issue(2, 1, 0, 32'h7, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        issue(2, 0, 1, 32'h4, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        issue(2, 1, 0, 32'h4, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);

        // Partial-lane write; write response returns the prior word
        issue(2, 0, 1, 32'h8, 4'hF, 32'h11223344, 32'h0, 0, 0);
        issue(2, 0, 1, 32'h8, 4'b0101, 32'hAABBCCDD, 32'h11223344, 0, 1);
        issue(2, 1, 0, 32'h8, 4'h0, 32'h0, 32'h11BB33DD, 0, 1);

        // rd+wr together: error, no write
        issue(2, 0, 1, 32'h0, 4'hF, 32'h12345678, 32'h0, 0, 0);
        issue(2, 1, 1, 32'h0, 4'hF, 32'h0, 32'h0, 1, 1);
        issue(2, 1, 0, 32'h0, 4'h0, 32'h0, 32'h12345678, 0, 1);

        // Range boundary: 0x40 errs and must not alias word 0; 0x3C is valid
        issue(2, 1, 0, 32'h40, 4'h0, 32'h0, 32'h0, 1, 1);
        issue(2, 0, 1, 32'h40, 4'hF, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(2, 1, 0, 32'h0, 4'h0, 32'h0, 32'h12345678, 0, 1);
        issue(2, 1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h0, 1, 1);
        issue(2, 0, 1, 32'h3C, 4'hF, 32'h5A5A5A5A, 32'h0, 0, 0);
        issue(2, 1, 0, 32'h3C, 4'h0, 32'h0, 32'h5A5A5A5A, 0, 1);

        // Reset during WAIT of a write: no response, no write
        issue(2, 0, 1, 32'hC, 4'hF, 32'h0BADCAFE, 32'h0, 0, 0);
        @(negedge clk);
        wr2 = 1'b1; a2 = 32'hC; m2 = 4'hF; d2 = 32'hFFFFFFFF;
        @(posedge clk);
        #1 wr2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_valid", {31'b0, v2}, 32'h0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        issue(2, 1, 0, 32'hC, 4'h0, 32'h0, 32'h0BADCAFE, 0, 1);

        // LATENCY=0 instance
        issue(0, 0, 1, 32'h10, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0);
        issue(0, 1, 0, 32'h10, 4'h0, 32'h0, 32'hCAFEF00D, 0, 1);

        // Read held high: one accept every second cycle
        @(negedge clk);
        rd0 = 1'b1; a0 = 32'h10; m0 = 4'h0; d0 = '0;
        for (int k = 0; k < 4; k++) begin
            it.data = 32'hCAFEF00D; it.err = 1'b0; it.chk = 1'b1; it.cyc = cyc + 1 + 2 * k;
            sq0.push_back(it);
        end
        repeat (7) @(posedge clk);
        #1 rd0 = 1'b0;
        repeat (3) @(posedge clk);

        repeat (4) @(negedge clk);
        chk("l2_queue_drained", 32'(sq2.size()), 32'h0);
        chk("l0_queue_drained", 32'(sq0.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
